// File: rtl/cpu_commit_seq_if.sv
// Bus between the execute stage / IO channels and the instruction-phase
// sequencer. The slave modport is the sequencer's side of the connection.
interface cpu_commit_seq_if #(
    parameter int PHASES = 4,
    parameter int PC_W   = 11,
    parameter int DATA_W = 8,
    parameter int NCH    = 1
);
    localparam int PH_W = $clog2(PHASES);

    logic                   stall;
    logic [PH_W-1:0]        phase;
    logic                   commit;
    logic [PC_W-1:0]        ex_pc;
    logic                   ex_intr_en;
    logic [PC_W-1:0]        ex_intr_pc;
    logic [PC_W-1:0]        ex_intr_vec;
    logic [NCH-1:0]         ex_ack;
    logic [NCH-1:0]         ex_tx_req;
    logic [NCH*DATA_W-1:0]  ex_tx_data;
    logic [NCH-1:0]         irr;
    logic [NCH*DATA_W-1:0]  rx_data;
    logic [NCH-1:0]         tx_busy;
    logic [PC_W-1:0]        pc;
    logic                   intr_en;
    logic [PC_W-1:0]        intr_pc;
    logic [PC_W-1:0]        intr_vec;
    logic [NCH-1:0]         sr_irr;
    logic [NCH*DATA_W-1:0]  sr_rx_data;
    logic [NCH-1:0]         sr_tx_busy;
    logic [NCH-1:0]         ack;
    logic [NCH-1:0]         tx_req;
    logic [NCH*DATA_W-1:0]  tx_data;

    modport master (
        output stall, ex_pc, ex_intr_en, ex_intr_pc, ex_intr_vec, ex_ack,
               ex_tx_req, ex_tx_data, irr, rx_data, tx_busy,
        input  phase, commit, pc, intr_en, intr_pc, intr_vec, sr_irr,
               sr_rx_data, sr_tx_busy, ack, tx_req, tx_data
    );

    modport slave (
        input  stall, ex_pc, ex_intr_en, ex_intr_pc, ex_intr_vec, ex_ack,
               ex_tx_req, ex_tx_data, irr, rx_data, tx_busy,
        output phase, commit, pc, intr_en, intr_pc, intr_vec, sr_irr,
               sr_rx_data, sr_tx_busy, ack, tx_req, tx_data
    );
endinterface

// File: rtl/cpu_commit_seq.sv
// Instruction-phase sequencer and special-register commit unit.
// A phase counter splits each instruction into PHASES clocks; at
// COMMIT_PHASE (unless stalled) the execute-stage next state and the
// external IO inputs are registered. Interrupt requests are captured in a
// sticky pending register so single-cycle pulses between commits survive.
module cpu_commit_seq #(
    parameter int PHASES       = 4,
    parameter int COMMIT_PHASE = 2,
    parameter int PC_W         = 11,
    parameter int DATA_W       = 8,
    parameter int NCH          = 1,
    parameter int RESET_PC     = 0
) (
    input  logic              clk,
    input  logic              reset,
    cpu_commit_seq_if.slave   bus
);
    localparam int              PH_W       = $clog2(PHASES);
    localparam logic [PH_W-1:0] LAST_PH    = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] CMT_PH     = PH_W'(COMMIT_PHASE);

    logic [PH_W-1:0]        phase_q;
    logic                   commit;
    logic [NCH-1:0]         ack_clr;
    logic [NCH-1:0]         pend_q;
    logic [PC_W-1:0]        pc_q;
    logic                   intr_en_q;
    logic [PC_W-1:0]        intr_pc_q;
    logic [PC_W-1:0]        intr_vec_q;
    logic [NCH-1:0]         sr_irr_q;
    logic [NCH*DATA_W-1:0]  sr_rx_data_q;
    logic [NCH-1:0]         sr_tx_busy_q;
    logic [NCH-1:0]         ack_q;
    logic [NCH-1:0]         tx_req_q;
    logic [NCH*DATA_W-1:0]  tx_data_q;

    // Reset gates commit so nothing registers while reset is held, even
    // when COMMIT_PHASE is 0 and the counter already sits there.
    assign commit  = ~reset & ~bus.stall & (phase_q == CMT_PH);
    assign ack_clr = commit ? bus.ex_ack : '0;

    // Phase counter: counts 0..PHASES-1 and wraps, frozen while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else if (!bus.stall) begin
            phase_q <= (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
        end
    end

    // Sticky interrupt pending: set by irr every clock, cleared only by a
    // committing acknowledge; a coincident set wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= bus.irr | (pend_q & ~ack_clr);
        end
    end

    // Commit registers: execute next-state and sampled IO, held between commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= PC_W'(RESET_PC);
            intr_en_q    <= 1'b0;
            intr_pc_q    <= '0;
            intr_vec_q   <= '0;
            sr_irr_q     <= '0;
            sr_rx_data_q <= '0;
            sr_tx_busy_q <= '0;
            ack_q        <= '0;
            tx_req_q     <= '0;
            tx_data_q    <= '0;
        end else if (commit) begin
            pc_q         <= bus.ex_pc;
            intr_en_q    <= bus.ex_intr_en;
            intr_pc_q    <= bus.ex_intr_pc;
            intr_vec_q   <= bus.ex_intr_vec;
            sr_irr_q     <= pend_q | bus.irr;
            sr_rx_data_q <= bus.rx_data;
            sr_tx_busy_q <= bus.tx_busy;
            ack_q        <= bus.ex_ack;
            tx_req_q     <= bus.ex_tx_req;
            tx_data_q    <= bus.ex_tx_data;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.commit     = commit;
    assign bus.pc         = pc_q;
    assign bus.intr_en    = intr_en_q;
    assign bus.intr_pc    = intr_pc_q;
    assign bus.intr_vec   = intr_vec_q;
    assign bus.sr_irr     = sr_irr_q;
    assign bus.sr_rx_data = sr_rx_data_q;
    assign bus.sr_tx_busy = sr_tx_busy_q;
    assign bus.ack        = ack_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.tx_data    = tx_data_q;
endmodule

// File: tb/tb_cpu_commit_seq.sv
// Bench for cpu_commit_seq: a 4-phase/2-channel instance (dut_a) and a
// 3-phase, commit-at-phase-0 instance with RESET_PC=5 (dut_b).
module tb_cpu_commit_seq;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cpu_commit_seq_if #(.PHASES(4), .PC_W(11), .DATA_W(8), .NCH(2)) ifa ();
    cpu_commit_seq_if #(.PHASES(3), .PC_W(11), .DATA_W(8), .NCH(1)) ifb ();

    cpu_commit_seq #(.PHASES(4), .COMMIT_PHASE(2), .PC_W(11), .DATA_W(8),
                     .NCH(2), .RESET_PC(0))
        dut_a (.clk(clk), .reset(reset_a), .bus(ifa));

    cpu_commit_seq #(.PHASES(3), .COMMIT_PHASE(0), .PC_W(11), .DATA_W(8),
                     .NCH(1), .RESET_PC(5))
        dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

    typedef struct {
        logic        stall;
        logic [10:0] ex_pc;
        logic        txr;
        logic [7:0]  txd;
        logic [1:0]  ph;
        logic        cm;
        logic [10:0] pc;
        logic        etxr;
        logic [7:0]  etxd;
    } vec_t;

    vec_t tbl [17];

    // reference model state for dut_a (random phase)
    int unsigned m_cyc;
    logic [10:0] m_pc, m_ipc, m_ivec;
    logic        m_ie;
    logic [1:0]  m_pend, m_sr_irr, m_busy, m_ack, m_txr;
    logic [15:0] m_rx, m_txd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_idle();
        ifa.stall = 0; ifa.ex_pc = '0; ifa.ex_intr_en = 0; ifa.ex_intr_pc = '0;
        ifa.ex_intr_vec = '0; ifa.ex_ack = '0; ifa.ex_tx_req = '0; ifa.ex_tx_data = '0;
        ifa.irr = '0; ifa.rx_data = '0; ifa.tx_busy = '0;
    endtask

    // Run dut_a until a commit cycle has been clocked; bounded.
    task automatic a_to_commit();
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            seen = ifa.commit;
            tick();
        end
        if (!seen) chk("commit_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        tbl[0]  = '{0, 11'd1, 0, 8'h00, 2'd0, 0, 11'd0, 0, 8'h00};
        tbl[1]  = '{0, 11'd1, 0, 8'h00, 2'd1, 0, 11'd0, 0, 8'h00};
        tbl[2]  = '{0, 11'd1, 1, 8'hA5, 2'd2, 1, 11'd0, 0, 8'h00};
        tbl[3]  = '{0, 11'd2, 0, 8'h00, 2'd3, 0, 11'd1, 1, 8'hA5};
        tbl[4]  = '{0, 11'd2, 0, 8'h00, 2'd0, 0, 11'd1, 1, 8'hA5};
        tbl[5]  = '{0, 11'd2, 0, 8'h00, 2'd1, 0, 11'd1, 1, 8'hA5};
        tbl[6]  = '{0, 11'd2, 0, 8'h00, 2'd2, 1, 11'd1, 1, 8'hA5};
        tbl[7]  = '{0, 11'd3, 0, 8'h00, 2'd3, 0, 11'd2, 0, 8'h00};
        tbl[8]  = '{0, 11'd3, 0, 8'h00, 2'd0, 0, 11'd2, 0, 8'h00};
        tbl[9]  = '{0, 11'd3, 0, 8'h00, 2'd1, 0, 11'd2, 0, 8'h00};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{1, 11'd3, 0, 8'h00, 2'd2, 0, 11'd2, 0, 8'h00};
        tbl[15] = '{0, 11'd3, 0, 8'h00, 2'd2, 1, 11'd2, 0, 8'h00};
        tbl[16] = '{0, 11'd4, 0, 8'h00, 2'd3, 0, 11'd3, 0, 8'h00};

        a_idle();
        ifb.stall = 0; ifb.ex_pc = '0; ifb.ex_intr_en = 0; ifb.ex_intr_pc = '0;
        ifb.ex_intr_vec = '0; ifb.ex_ack = '0; ifb.ex_tx_req = '0; ifb.ex_tx_data = '0;
        ifb.irr = '0; ifb.rx_data = '0; ifb.tx_busy = '0;
        reset_a = 1; reset_b = 1;

        // reset state
        @(negedge clk);
        #1;
        chk("rst_phase", 32'(ifa.phase), 0);
        chk("rst_commit", 32'(ifa.commit), 0);
        chk("rst_pc", 32'(ifa.pc), 0);
        chk("rst_tx_req", 32'(ifa.tx_req), 0);
        chk("rst_sr_irr", 32'(ifa.sr_irr), 0);
        tick();
        reset_a = 0;

        // table: commit cadence, tx hold, stall at commit phase
        for (int i = 0; i < 17; i++) begin
            ifa.stall      = tbl[i].stall;
            ifa.ex_pc      = tbl[i].ex_pc;
            ifa.ex_tx_req  = {1'b0, tbl[i].txr};
            ifa.ex_tx_data = {8'h00, tbl[i].txd};
            #1;
            chk($sformatf("tbl%0d_phase", i), 32'(ifa.phase), 32'(tbl[i].ph));
            chk($sformatf("tbl%0d_commit", i), 32'(ifa.commit), 32'(tbl[i].cm));
            chk($sformatf("tbl%0d_pc", i), 32'(ifa.pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_tx_req", i), 32'(ifa.tx_req), {31'd0, tbl[i].etxr});
            chk($sformatf("tbl%0d_tx_data", i), 32'(ifa.tx_data), {24'd0, tbl[i].etxd});
            tick();
        end
        a_idle();

        // 1-cycle irr[1] pulse at phase 0, sticky until an acknowledged commit
        #1;
        chk("irq_pulse_phase", 32'(ifa.phase), 0);
        ifa.irr = 2'b10;
        tick();
        ifa.irr = 2'b00;
        a_to_commit(); #1;
        chk("irq_sr1", 32'(ifa.sr_irr), 32'b10);
        a_to_commit(); #1;
        chk("irq_sr2", 32'(ifa.sr_irr), 32'b10);
        ifa.ex_ack = 2'b10;
        a_to_commit(); #1;
        chk("irq_sr_ackcommit", 32'(ifa.sr_irr), 32'b10);
        chk("irq_ack_out", 32'(ifa.ack), 32'b10);
        ifa.ex_ack = 2'b00;
        a_to_commit(); #1;
        chk("irq_sr_cleared", 32'(ifa.sr_irr), 0);
        chk("irq_ack_dropped", 32'(ifa.ack), 0);

        // set and acknowledge coincide on channel 0: set wins
        ifa.irr = 2'b01;
        tick();
        ifa.irr = 2'b00;
        tick(); tick();
        ifa.irr = 2'b01; ifa.ex_ack = 2'b01;
        #1;
        chk("coinc_phase", 32'(ifa.phase), 2);
        chk("coinc_commit", 32'(ifa.commit), 1);
        tick();
        ifa.irr = 2'b00; ifa.ex_ack = 2'b00;
        #1;
        chk("coinc_sr", 32'(ifa.sr_irr), 32'b01);
        a_to_commit(); #1;
        chk("coinc_pend_kept", 32'(ifa.sr_irr), 32'b01);
        ifa.ex_ack = 2'b01;
        a_to_commit(); #1;
        ifa.ex_ack = 2'b00;
        a_to_commit(); #1;
        chk("coinc_cleared", 32'(ifa.sr_irr), 0);

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic cm;
            reset_a         = (i == 0) || ($urandom % 60 == 0);
            ifa.stall       = ($urandom % 4 == 0);
            ifa.ex_pc       = 11'($urandom);
            ifa.ex_intr_en  = 1'($urandom);
            ifa.ex_intr_pc  = 11'($urandom);
            ifa.ex_intr_vec = 11'($urandom);
            ifa.ex_ack      = 2'($urandom);
            ifa.ex_tx_req   = 2'($urandom);
            ifa.ex_tx_data  = 16'($urandom);
            ifa.irr         = {1'($urandom % 5 == 0), 1'($urandom % 5 == 0)};
            ifa.rx_data     = 16'($urandom);
            ifa.tx_busy     = 2'($urandom);
            #1;
            cm = !reset_a && !ifa.stall && (m_cyc % 4 == 2);
            if (i > 0) begin
                chk("rnd_phase", 32'(ifa.phase), m_cyc % 4);
                chk("rnd_commit", 32'(ifa.commit), 32'(cm));
                chk("rnd_pc", 32'(ifa.pc), 32'(m_pc));
                chk("rnd_intr_en", 32'(ifa.intr_en), 32'(m_ie));
                chk("rnd_intr_pc", 32'(ifa.intr_pc), 32'(m_ipc));
                chk("rnd_intr_vec", 32'(ifa.intr_vec), 32'(m_ivec));
                chk("rnd_sr_irr", 32'(ifa.sr_irr), 32'(m_sr_irr));
                chk("rnd_sr_rx", 32'(ifa.sr_rx_data), 32'(m_rx));
                chk("rnd_sr_busy", 32'(ifa.sr_tx_busy), 32'(m_busy));
                chk("rnd_ack", 32'(ifa.ack), 32'(m_ack));
                chk("rnd_tx_req", 32'(ifa.tx_req), 32'(m_txr));
                chk("rnd_tx_data", 32'(ifa.tx_data), 32'(m_txd));
            end
            if (reset_a) begin
                m_cyc = 0; m_pc = 0; m_ie = 0; m_ipc = 0; m_ivec = 0; m_pend = 0;
                m_sr_irr = 0; m_rx = 0; m_busy = 0; m_ack = 0; m_txr = 0; m_txd = 0;
            end else begin
                if (cm) begin
                    m_pc = ifa.ex_pc; m_ie = ifa.ex_intr_en; m_ipc = ifa.ex_intr_pc;
                    m_ivec = ifa.ex_intr_vec; m_sr_irr = m_pend | ifa.irr;
                    m_rx = ifa.rx_data; m_busy = ifa.tx_busy; m_ack = ifa.ex_ack;
                    m_txr = ifa.ex_tx_req; m_txd = ifa.ex_tx_data;
                    m_pend = ifa.irr | (m_pend & ~ifa.ex_ack);
                end else begin
                    m_pend = m_pend | ifa.irr;
                end
                if (!ifa.stall) m_cyc++;
            end
            tick();
        end
        reset_a = 0;

        // dut_b: commit at phase 0, reset mid-instruction discards state
        ifb.ex_pc = 11'd7; ifb.ex_intr_en = 1; ifb.ex_tx_req = 1'b1; ifb.ex_tx_data = 8'h3C;
        #1;
        chk("b_rst_commit", 32'(ifb.commit), 0);
        tick();
        reset_b = 0;
        #1;
        chk("b_first_phase", 32'(ifb.phase), 0);
        chk("b_first_commit", 32'(ifb.commit), 1);
        chk("b_first_pc", 32'(ifb.pc), 5);
        tick();
        #1;
        chk("b_ph1_phase", 32'(ifb.phase), 1);
        chk("b_ph1_pc", 32'(ifb.pc), 7);
        chk("b_ph1_tx_req", 32'(ifb.tx_req), 1);
        chk("b_ph1_intr_en", 32'(ifb.intr_en), 1);
        reset_b = 1;
        #1;
        chk("b_midrst_commit", 32'(ifb.commit), 0);
        tick();
        reset_b = 0;
        #1;
        chk("b_after_phase", 32'(ifb.phase), 0);
        chk("b_after_pc", 32'(ifb.pc), 5);
        chk("b_after_tx_req", 32'(ifb.tx_req), 0);
        chk("b_after_tx_data", 32'(ifb.tx_data), 0);
        chk("b_after_intr_en", 32'(ifb.intr_en), 0);
        chk("b_after_commit", 32'(ifb.commit), 1);
        tick();
        #1;
        chk("b_recommit_pc", 32'(ifb.pc), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
